// File: rtl/fv_bank_req_arbiter.sv
// Arbitrates one Big FV SRAM bank controller between NUM_PE Edge-PE readers and a
// multi-beat write-back source; drives a single registered request packet to the bank.
module fv_bank_req_arbiter #(
  parameter int unsigned NUM_PE          = 4,
  parameter int unsigned NODE_ID_W       = 8,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned WB_STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          update_phase,
  input  logic                          bank_available,
  input  logic [NUM_PE-1:0]             pe_req_valid,
  input  logic [NUM_PE*NODE_ID_W-1:0]   pe_req_node_id,
  output logic [NUM_PE-1:0]             pe_req_ready,
  input  logic                          wb_valid,
  input  logic [NODE_ID_W-1:0]          wb_node_id,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          wb_last,
  output logic                          wb_ready,
  output logic                          req_valid,
  output logic                          req_rd_wr,
  output logic [NODE_ID_W-1:0]          req_node_id,
  output logic [$clog2(NUM_PE)-1:0]     req_pe_tag,
  output logic [DATA_W-1:0]             req_data,
  output logic                          req_wr_eos,
  output logic                          burst_err
);

  // NUM_PE is expected to be a power of two so the pointer wraps naturally.
  localparam int unsigned TAG_W = $clog2(NUM_PE);
  localparam int unsigned CNT_W = $clog2(WB_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(WB_STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 rd_wr;
    logic [NODE_ID_W-1:0] node_id;
    logic [TAG_W-1:0]     pe_tag;
    logic [DATA_W-1:0]    data;
    logic                 wr_eos;
  } req_t;

  state_t               r_state, w_state_nxt;
  logic [TAG_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_starve, w_starve_nxt;
  logic                 r_burst_err, w_burst_err_nxt;
  req_t                 r_req, w_req_nxt;

  logic [NODE_ID_W-1:0] w_pe_node [NUM_PE];
  logic [TAG_W-1:0]     w_rr_idx;
  logic [TAG_W-1:0]     w_pe_idx;
  logic                 w_pe_found;
  logic                 w_any_pe;
  logic                 w_grant_ok;
  logic                 w_wb_wins;

  genvar g;
  generate
    for (g = 0; g < NUM_PE; g++) begin : g_slice
      assign w_pe_node[g] = pe_req_node_id[g*NODE_ID_W +: NODE_ID_W];
    end
  endgenerate

  // Round-robin search starting one past the last granted PE.
  always_comb begin
    w_pe_found = 1'b0;
    w_pe_idx   = '0;
    w_rr_idx   = '0;
    for (int unsigned k = 1; k <= NUM_PE; k++) begin
      w_rr_idx = r_ptr + TAG_W'(k);
      if (!w_pe_found && pe_req_valid[w_rr_idx]) begin
        w_pe_found = 1'b1;
        w_pe_idx   = w_rr_idx;
      end
    end
  end

  assign w_any_pe   = |pe_req_valid;
  assign w_grant_ok = reset && update_phase && bank_available;
  assign w_wb_wins  = wb_valid && (!w_any_pe || (r_starve < STARVE_MAX));

  // Next-state, next request packet and combinational accept pulses.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_starve_nxt    = r_starve;
    w_burst_err_nxt = r_burst_err;
    w_req_nxt       = '0;
    pe_req_ready    = '0;
    wb_ready        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_grant_ok && w_wb_wins) begin
          wb_ready          = 1'b1;
          w_req_nxt.valid   = 1'b1;
          w_req_nxt.rd_wr   = 1'b1;
          w_req_nxt.node_id = wb_node_id;
          w_req_nxt.data    = wb_data;
          w_req_nxt.wr_eos  = wb_last;
          if (!w_any_pe) begin
            w_starve_nxt = '0;
          end else if (r_starve < STARVE_MAX) begin
            w_starve_nxt = r_starve + CNT_W'(1);
          end
          w_state_nxt = wb_last ? S_GAP : S_BURST;
        end else if (w_grant_ok && w_pe_found) begin
          pe_req_ready[w_pe_idx] = 1'b1;
          w_req_nxt.valid        = 1'b1;
          w_req_nxt.node_id      = w_pe_node[w_pe_idx];
          w_req_nxt.pe_tag       = w_pe_idx;
          w_ptr_nxt              = w_pe_idx;
          w_starve_nxt           = '0;
          w_state_nxt            = S_GAP;
        end
      end

      S_BURST: begin
        wb_ready          = 1'b1;
        w_req_nxt.valid   = 1'b1;
        w_req_nxt.rd_wr   = 1'b1;
        w_req_nxt.node_id = r_req.node_id;
        if (wb_valid) begin
          w_req_nxt.data   = wb_data;
          w_req_nxt.wr_eos = wb_last;
          w_state_nxt      = wb_last ? S_GAP : S_BURST;
        end else begin
          // Source dropped mid-burst: close the bank's burst with an empty last beat.
          w_burst_err_nxt  = 1'b1;
          w_req_nxt.wr_eos = 1'b1;
          w_state_nxt      = S_GAP;
        end
      end

      // bank_available is stale this cycle, so no grant is allowed.
      S_GAP: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= TAG_W'(NUM_PE - 1);
      r_starve    <= '0;
      r_burst_err <= 1'b0;
      r_req       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_starve    <= w_starve_nxt;
      r_burst_err <= w_burst_err_nxt;
      r_req       <= w_req_nxt;
    end
  end

  assign req_valid   = r_req.valid;
  assign req_rd_wr   = r_req.rd_wr;
  assign req_node_id = r_req.node_id;
  assign req_pe_tag  = r_req.pe_tag;
  assign req_data    = r_req.data;
  assign req_wr_eos  = r_req.wr_eos;
  assign burst_err   = r_burst_err;

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// Self-checking bench for fv_bank_req_arbiter: directed scenarios followed by random
// traffic compared against a transaction-level reference model.
module tb_fv_bank_req_arbiter;

  localparam int NUM_PE = 4;
  localparam int LIMIT  = 4;

  logic        clk;
  logic        reset;
  logic        update_phase;
  logic        bank_available;
  logic [3:0]  pe_req_valid;
  logic [31:0] pe_req_node_id;
  logic [3:0]  pe_req_ready;
  logic        wb_valid;
  logic [7:0]  wb_node_id;
  logic [63:0] wb_data;
  logic        wb_last;
  logic        wb_ready;
  logic        req_valid;
  logic        req_rd_wr;
  logic [7:0]  req_node_id;
  logic [1:0]  req_pe_tag;
  logic [63:0] req_data;
  logic        req_wr_eos;
  logic        burst_err;

  fv_bank_req_arbiter #(
    .NUM_PE(NUM_PE), .NODE_ID_W(8), .DATA_W(64), .WB_STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .update_phase(update_phase), .bank_available(bank_available),
    .pe_req_valid(pe_req_valid), .pe_req_node_id(pe_req_node_id), .pe_req_ready(pe_req_ready),
    .wb_valid(wb_valid), .wb_node_id(wb_node_id), .wb_data(wb_data), .wb_last(wb_last),
    .wb_ready(wb_ready), .req_valid(req_valid), .req_rd_wr(req_rd_wr),
    .req_node_id(req_node_id), .req_pe_tag(req_pe_tag), .req_data(req_data),
    .req_wr_eos(req_wr_eos), .burst_err(burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Reference model: mode 0 = free, 1 = one-cycle cool-down, 2 = inside a write burst.
  int          m_mode, m_ptr, m_starve;
  logic        m_err;
  logic        e_valid, e_rw, e_eos;
  logic [7:0]  e_node;
  logic [1:0]  e_tag;
  logic [63:0] e_data;
  int          n_mode, n_ptr, n_starve;
  logic        n_err, n_valid, n_rw, n_eos;
  logic [7:0]  n_node;
  logic [1:0]  n_tag;
  logic [63:0] n_data;
  logic [3:0]  x_pe_ready;
  logic        x_wb_ready;
  logic [3:0]  s_pe_ready;
  logic        s_wb_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_ptr = NUM_PE - 1; m_starve = 0; m_err = 1'b0;
    e_valid = 1'b0; e_rw = 1'b0; e_eos = 1'b0; e_node = '0; e_tag = '0; e_data = '0;
  endfunction

  function automatic void model_eval();
    int  best, best_d, d;
    bit  any;
    n_mode = m_mode; n_ptr = m_ptr; n_starve = m_starve; n_err = m_err;
    n_valid = 1'b0; n_rw = 1'b0; n_eos = 1'b0; n_node = '0; n_tag = '0; n_data = '0;
    x_pe_ready = '0; x_wb_ready = 1'b0;
    any = (pe_req_valid != 4'b0);
    if (m_mode == 0) begin
      if (update_phase && bank_available) begin
        if (wb_valid && (!any || m_starve < LIMIT)) begin
          x_wb_ready = 1'b1;
          n_valid = 1'b1; n_rw = 1'b1; n_node = wb_node_id; n_data = wb_data; n_eos = wb_last;
          n_starve = any ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
          n_mode = wb_last ? 1 : 2;
        end else if (any) begin
          // Nearest valid PE after the previous winner, by circular distance.
          best = 0; best_d = NUM_PE;
          for (int i = 0; i < NUM_PE; i++) begin
            d = (i - m_ptr - 1 + 2 * NUM_PE) % NUM_PE;
            if (pe_req_valid[2'(i)] && d < best_d) begin
              best_d = d; best = i;
            end
          end
          x_pe_ready = 4'b0001 << best;
          n_valid = 1'b1; n_node = 8'(pe_req_node_id >> (best * 8)); n_tag = 2'(best);
          n_ptr = best; n_starve = 0; n_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      n_mode = 0;
    end else begin
      x_wb_ready = 1'b1;
      n_valid = 1'b1; n_rw = 1'b1; n_node = e_node;
      if (wb_valid) begin
        n_data = wb_data; n_eos = wb_last; n_mode = wb_last ? 1 : 2;
      end else begin
        n_err = 1'b1; n_eos = 1'b1; n_mode = 1;
      end
    end
  endfunction

  function automatic void model_commit();
    m_mode = n_mode; m_ptr = n_ptr; m_starve = n_starve; m_err = n_err;
    e_valid = n_valid; e_rw = n_rw; e_eos = n_eos; e_node = n_node; e_tag = n_tag; e_data = n_data;
  endfunction

  task automatic chk_req();
    chk("req_valid",   64'(req_valid),   64'(e_valid));
    chk("req_rd_wr",   64'(req_rd_wr),   64'(e_rw));
    chk("req_node_id", 64'(req_node_id), 64'(e_node));
    chk("req_pe_tag",  64'(req_pe_tag),  64'(e_tag));
    chk("req_data",    req_data,         e_data);
    chk("req_wr_eos",  64'(req_wr_eos),  64'(e_eos));
    chk("burst_err",   64'(burst_err),   64'(m_err));
  endtask

  // One clock: check accept pulses mid-cycle, then registered packet after the edge.
  task automatic step();
    #1;
    model_eval();
    s_pe_ready = pe_req_ready;
    s_wb_ready = wb_ready;
    chk("pe_req_ready", 64'(pe_req_ready), 64'(x_pe_ready));
    chk("wb_ready",     64'(wb_ready),     64'(x_wb_ready));
    @(posedge clk);
    model_commit();
    @(negedge clk);
    chk_req();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    update_phase = 1'b0; bank_available = 1'b0;
    pe_req_valid = '0; pe_req_node_id = '0;
    wb_valid = 1'b0; wb_node_id = '0; wb_data = '0; wb_last = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int q[$];
  int exp_rr[5];
  int exp_sv[6];
  bit src_active;
  int src_len, src_beat;

  initial begin
    n_assert = 0; n_fail = 0;
    exp_rr = '{0, 1, 2, 3, 0};
    exp_sv = '{9, 9, 9, 9, 1, 9};

    // Reset state.
    do_reset();
    chk("rst_req_valid", 64'(req_valid), 64'(0));
    chk("rst_req_data",  req_data,       64'(0));
    chk("rst_burst_err", 64'(burst_err), 64'(0));
    chk_req();

    // Single PE2 read.
    update_phase = 1'b1; bank_available = 1'b1;
    pe_req_valid = 4'b0100; pe_req_node_id = 32'h0015_0000;
    step();
    chk("t1_ready", 64'(s_pe_ready), 64'(4'b0100));
    chk("t1_node",  64'(req_node_id), 64'(8'h15));
    chk("t1_tag",   64'(req_pe_tag),  64'(2));
    chk("t1_rdwr",  64'(req_rd_wr),   64'(0));
    pe_req_valid = '0;
    step();
    chk("t1_gap_ready", 64'(s_pe_ready), 64'(0));

    // Round robin with all PEs continuously valid.
    do_reset();
    update_phase = 1'b1; bank_available = 1'b1;
    pe_req_valid = 4'b1111; pe_req_node_id = 32'h1312_1110;
    q.delete();
    for (int c = 0; c < 10; c++) begin
      step();
      if (req_valid) q.push_back(int'(req_pe_tag));
    end
    chk("rr_count", 64'(q.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < q.size()) chk("rr_tag", 64'(q[i]), 64'(exp_rr[i]));

    // Update phase low blocks everything; write-back wins once it rises.
    update_phase = 1'b0;
    pe_req_valid = 4'b0010; pe_req_node_id = 32'h0000_2100;
    wb_valid = 1'b1; wb_node_id = 8'h33; wb_data = 64'hDEAD; wb_last = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("up0_ready", 64'(s_pe_ready), 64'(0));
    chk("up0_valid", 64'(req_valid),  64'(0));
    update_phase = 1'b1;
    step();
    chk("up1_wb_ready", 64'(s_wb_ready), 64'(1));
    chk("up1_pe_ready", 64'(s_pe_ready), 64'(0));
    wb_valid = 1'b0; pe_req_valid = '0;
    step();

    // Three-beat write-back burst to node 0x20.
    wb_valid = 1'b1; wb_node_id = 8'h20; wb_last = 1'b0; wb_data = 64'hAAAA_0000_0000_000A;
    step();
    chk("b3_a",     req_data, 64'hAAAA_0000_0000_000A);
    chk("b3_eos_a", 64'(req_wr_eos), 64'(0));
    wb_data = 64'hBBBB_0000_0000_000B;
    step();
    chk("b3_b",     req_data, 64'hBBBB_0000_0000_000B);
    chk("b3_node",  64'(req_node_id), 64'(8'h20));
    wb_data = 64'hCCCC_0000_0000_000C; wb_last = 1'b1;
    step();
    chk("b3_c",     req_data, 64'hCCCC_0000_0000_000C);
    chk("b3_eos_c", 64'(req_wr_eos), 64'(1));
    wb_valid = 1'b0; wb_last = 1'b0;
    step();
    chk("b3_gap", 64'(req_valid), 64'(0));
    step();

    // Write-back starvation bound with PE1 waiting.
    wb_valid = 1'b1; wb_node_id = 8'h44; wb_data = 64'h5; wb_last = 1'b1;
    pe_req_valid = 4'b0010; pe_req_node_id = 32'h0000_5100;
    q.delete();
    for (int c = 0; c < 12; c++) begin
      step();
      if (req_valid) q.push_back(req_rd_wr ? 9 : int'(req_pe_tag));
      if (s_pe_ready[1]) pe_req_valid = '0;
    end
    chk("sv_count", 64'(q.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      if (i < q.size()) chk("sv_grant", 64'(q[i]), 64'(exp_sv[i]));

    // Source drops valid on beat 2.
    wb_valid = 1'b0;
    step();
    wb_valid = 1'b1; wb_node_id = 8'h66; wb_data = 64'h77; wb_last = 1'b0;
    step();
    wb_valid = 1'b0;
    step();
    chk("err_flag",  64'(burst_err),  64'(1));
    chk("err_eos",   64'(req_wr_eos), 64'(1));
    chk("err_data",  req_data,        64'(0));
    step();
    step();
    chk("err_sticky", 64'(burst_err), 64'(1));

    // Reset in the middle of a burst.
    wb_valid = 1'b1; wb_data = 64'h99;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(req_valid),    64'(0));
    chk("mid_rst_data",  req_data,          64'(0));
    chk("mid_rst_err",   64'(burst_err),    64'(0));
    chk("mid_rst_wbrdy", 64'(wb_ready),     64'(0));
    chk("mid_rst_perdy", 64'(pe_req_ready), 64'(0));

    // Random traffic against the reference model.
    do_reset();
    src_active = 1'b0; src_len = 0; src_beat = 0;
    for (int c = 0; c < 3000; c++) begin
      update_phase   = ($urandom % 10) != 0;
      bank_available = ($urandom % 10) < 7;
      for (int i = 0; i < NUM_PE; i++) begin
        if (!pe_req_valid[2'(i)] && ($urandom % 4) == 0) begin
          pe_req_valid[2'(i)] = 1'b1;
          pe_req_node_id = (pe_req_node_id & ~(32'hFF << (i * 8))) |
                           (32'(8'($urandom)) << (i * 8));
        end
      end
      if (!src_active && ($urandom % 4) == 0) begin
        src_active = 1'b1; src_len = 1 + int'($urandom % 4); src_beat = 0;
        wb_node_id = 8'($urandom);
        wb_data = {$urandom, $urandom};
      end
      wb_valid = src_active;
      wb_last  = src_active && (src_beat == src_len - 1);
      step();
      if (x_wb_ready && wb_valid) begin
        src_beat++;
        wb_data = {$urandom, $urandom};
        if (src_beat == src_len) src_active = 1'b0;
      end
      pe_req_valid = pe_req_valid & ~x_pe_ready;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fv_bank_req_arbiter.md
Name: fv_bank_req_arbiter

Overview:
- Shares one Big FV SRAM bank controller between NUM_PE Edge-PE read requesters and one write-back source (accumulate/vertex buffer).
- Only issues requests during the update phase, and only when the bank controller reports available.
- Registers a single request packet toward the bank controller.
- Sequences multi-beat write-back bursts, round-robins PE reads, and bounds PE starvation under write-back pressure.

Parameters:
- NUM_PE, 4, number of Edge-PE requesters; also the width source for the PE tag, log2(NUM_PE).
- NODE_ID_W, 8, node id width.
- DATA_W, 64, feature-value beat width (FV bandwidth).
- WB_STARVE_LIMIT, 4, maximum consecutive write-back grants while any PE request is pending.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- update_phase  in  1  high = update phase (update-iteration LSB); grants allowed only when high
- bank_available  in  1  bank controller in IDLE
- pe_req_valid  in  NUM_PE  per-PE read request, held until accepted
- pe_req_node_id  in  NUM_PE*NODE_ID_W  per-PE node id, slice i belongs to PE i
- pe_req_ready  out  NUM_PE  one-cycle accept pulse, one-hot
- wb_valid  in  1  write-back beat valid
- wb_node_id  in  NODE_ID_W  write-back node id, constant across a burst
- wb_data  in  DATA_W  write-back beat data
- wb_last  in  1  final beat of a burst
- wb_ready  out  1  beat accepted this cycle
- req_valid  out  1  request packet valid to bank controller
- req_rd_wr  out  1  1 = write-back, 0 = PE read
- req_node_id  out  NODE_ID_W  request node id
- req_pe_tag  out  log2(NUM_PE)  granted PE index; 0 for writes
- req_data  out  DATA_W  write beat data; 0 for reads
- req_wr_eos  out  1  last write beat
- burst_err  out  1  sticky: wb_valid low during a burst

Behaviour:
- Reset: all outputs and registers are 0. State = IDLE, round-robin pointer = NUM_PE-1, starvation counter = 0.
- Reset may assert in any state. Any in-flight burst is abandoned and all registers return to their reset values.
- All req_* outputs are registered. A decision made in cycle N appears on req_* in cycle N+1. Ready pulses are combinational in cycle N.
- States: IDLE, GAP, BURST.
- IDLE, grant condition: a grant requires update_phase && bank_available. Priority when the condition holds:
  - Write-back wins if wb_valid && (no pe_req_valid || starve_cnt < WB_STARVE_LIMIT).
  - Otherwise the first valid PE searching from pointer+1, modulo NUM_PE.
- IDLE, write-back grant:
  - wb_ready=1 and the beat is captured.
  - Next cycle: req_valid=1, rd_wr=1, node_id=wb_node_id, data=wb_data, wr_eos=wb_last.
  - starve_cnt increments (saturating) if any pe_req_valid is pending, else clears.
  - Next state: GAP if wb_last, else BURST.
- IDLE, PE grant:
  - pe_req_ready[i]=1.
  - Next cycle: req_valid=1, rd_wr=0, node_id=slice i, pe_tag=i.
  - pointer=i, starve_cnt=0, next state GAP.
- IDLE, no grant: req_valid=0.
- BURST:
  - wb_ready=1 every cycle and node_id is held.
  - Each cycle, the captured beat drives req_valid=1, rd_wr=1, data, wr_eos=wb_last.
  - On wb_last, go to GAP.
  - If wb_valid=0: set burst_err, drive wr_eos=1 with data 0, and go to GAP. This terminates the bank's write burst.
- GAP:
  - Exactly one cycle with no grant; req_valid shows the final issued packet.
  - Purpose: bank_available still reads high in this cycle because the bank registers its state change on this edge, so no grant may be based on it.
  - Then return to IDLE.
- update_phase falling: no new grants. An in-progress burst completes normally.
- Simultaneous valid PEs: exactly one is granted per IDLE grant. With all PEs continuously valid and no write-back, grants rotate 0,1,2,3,0…
- Unaccepted requests: pe_req_ready stays 0. Requesters hold valid and node id.

Test Plan:
- After reset, bank_available=1, update_phase=1, PE2 requests node 0x15 → cycle N: pe_req_ready=4'b0100. Cycle N+1: req_valid=1, rd_wr=0, node_id=0x15, pe_tag=2. No grant at N+1.
- All 4 PEs valid, bank always available → grants PE0,1,2,3,0 at a spacing of two cycles each (grant + GAP). pe_tag sequence 0,1,2,3,0.
- update_phase=0 with PE and write-back requests valid → no ready pulses, req_valid=0. Raising update_phase → write-back is granted first.
- 3-beat write-back to node 0x20 with data A,B,C → req_valid high for 3 consecutive cycles with data A,B,C, node 0x20. wr_eos=1 only on C. Then GAP, then IDLE.
- Write-back continuously valid (single-beat bursts) plus PE1 valid, WB_STARVE_LIMIT=4 → four write-back grants, then PE1 granted, then starve_cnt=0 and write-back resumes.
- wb_valid drops on beat 2 of a burst → burst_err=1 (sticky), req_wr_eos=1 with data 0, state returns to IDLE. Reset asserted mid-burst → all outputs 0 immediately.
